// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit:
// func3 encodings, the M-extension func7 value, FSM state encoding and
// small decode helpers used by both the top level and the operand prep.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [6:0] M_EXT_FUNC7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Any divide-family op (DIV, DIVU, REM, REMU).
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Remainder ops return the high half of the divide accumulator.
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // Signed divide ops, the only ones subject to the overflow special case.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning for ex_muldiv_unit.
// Front half: turns the incoming operands into unsigned magnitudes and
// computes the sign the final result must carry.
// Back half: applies that sign to the finished accumulator and selects the
// architectural result word for the latched operation.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        req_func3,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              res_sign,
  input  logic [2:0]        op_func3,
  input  logic              op_sign,
  input  logic [2*XLEN-1:0] raw,
  output logic [XLEN-1:0]   fixed
);

  logic              a_signed;
  logic              b_signed;
  logic              neg_a;
  logic              neg_b;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_word;

  // Decode operand signedness, take magnitudes and derive the result sign.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (req_func3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase

    neg_a = a_signed & rs1_val[XLEN-1];
    neg_b = b_signed & rs2_val[XLEN-1];

    // The most negative value maps onto itself, which is still the correct
    // unsigned magnitude.
    abs_a = neg_a ? -rs1_val : rs1_val;
    abs_b = neg_b ? -rs2_val : rs2_val;

    // Remainder follows the dividend; product and quotient follow the xor.
    if (is_rem(req_func3)) res_sign = neg_a;
    else                   res_sign = neg_a ^ neg_b;
  end

  // Apply the recorded sign and pick the result word for the latched op.
  always_comb begin
    prod_fixed = op_sign ? -raw : raw;
    div_word   = is_rem(op_func3) ? raw[2*XLEN-1:XLEN] : raw[XLEN-1:0];
    if (is_div(op_func3))       fixed = op_sign ? -div_word : div_word;
    else if (op_func3 == F3_MUL) fixed = prod_fixed[XLEN-1:0];
    else                         fixed = prod_fixed[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit.
// Accepts an M-extension instruction from the ID/EX bundle, runs an
// iterative shift-add multiply or restoring divide (one bit per cycle),
// stalls the front end meanwhile and pulses res_valid for one cycle with
// the result and destination register.
// Optional build macro MULDIV_ZERO_SKIP_EN: a multiply with a zero operand
// finishes one cycle after acceptance instead of iterating.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT   // 2**CNT_W must exceed XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t state;
  state_t state_next;

  // Operation context captured at acceptance.
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic              sign_lat;
  logic [CNT_W-1:0]  count;
  // Multiply: {partial high, multiplier}; divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;
  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0]   opnd;

  logic              req;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              res_sign;
  logic [XLEN-1:0]   fixed;

  logic              div_zero;
  logic              div_ovf;
  logic              zero_skip;
  logic              early_done;
  logic [XLEN-1:0]   early_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] iter_next;
  logic              last_iter;

  assign req = id_valid && (func7 == M_EXT_FUNC7);

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .req_func3 (func3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .res_sign  (res_sign),
    .op_func3  (op),
    .op_sign   (sign_lat),
    .raw       (iter_next),
    .fixed     (fixed)
  );

  // Resolve the cases that finish without iterating.
  always_comb begin
    div_zero = is_div(func3) && (rs2_val == '0);
    div_ovf  = is_signed_div(func3) && (rs1_val == MIN_INT) && (rs2_val == '1);
`ifdef MULDIV_ZERO_SKIP_EN
    zero_skip = !is_div(func3) && ((rs1_val == '0) || (rs2_val == '0));
`else
    zero_skip = 1'b0;
`endif
    early_done = div_zero || div_ovf || zero_skip;
    early_res  = '0;
    if (div_zero)     early_res = is_rem(func3) ? rs1_val : '1;
    else if (div_ovf) early_res = is_rem(func3) ? '0 : MIN_INT;
  end

  // One shift-add or restoring-divide step on the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    // The remainder stays below the divisor, so bit XLEN of the difference
    // is set exactly when the trial subtraction borrows.
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    iter_next = is_div(op) ? div_next : mul_next;
    last_iter = (count == LAST_CNT);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = early_done ? DONE : BUSY;
      BUSY: if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; stall covers the acceptance cycle too.
  always_comb begin
    stall     = ((state == IDLE) && req) || (state == BUSY);
    res_valid = (state == DONE);
  end

  // Datapath: capture operands, iterate, and publish the result into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      rd_lat   <= '0;
      sign_lat <= 1'b0;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op       <= func3;
            rd_lat   <= rd;
            sign_lat <= res_sign;
            count    <= '0;
            acc      <= {{XLEN{1'b0}}, is_div(func3) ? abs_a : abs_b};
            opnd     <= is_div(func3) ? abs_b : abs_a;
            if (early_done) begin
              result <= early_res;
              rd_out <= rd;
            end
          end
        end
        BUSY: begin
          acc   <= iter_next;
          count <= count + 1'b1;
          if (last_iter) begin
            result <= fixed;
            rd_out <= rd_lat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
